// File: rtl/axi_sram_bridge_pkg.sv
// Shared IDs, FSM encodings, AXI tie-off constants and request payloads for the SRAM-to-AXI bridge.
package axi_sram_bridge_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ID_W     = 4;
  localparam int unsigned STRB_W   = 4;
  localparam int unsigned SIZE_W   = 2;
  localparam int unsigned AXSIZE_W = 3;

  localparam logic [ID_W-1:0] ID_INST = ID_W'(0);
  localparam logic [ID_W-1:0] ID_DATA = ID_W'(1);

  // Single-beat INCR transfers, normal access, fixed write id.
  localparam logic [3:0]      AX_LEN   = 4'd0;
  localparam logic [1:0]      AX_BURST = 2'b01;
  localparam logic [1:0]      AX_LOCK  = 2'b00;
  localparam logic [3:0]      AX_CACHE = 4'b0000;
  localparam logic [2:0]      AX_PROT  = 3'b000;
  localparam logic [ID_W-1:0] WR_ID    = ID_W'(1);
  localparam logic            W_LAST   = 1'b1;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SEND = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic [ADDR_W-1:0]   addr;
    logic [AXSIZE_W-1:0] size;
  } ar_req_t;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [AXSIZE_W-1:0] size;
    logic [DATA_W-1:0]   data;
    logic [STRB_W-1:0]   strb;
  } aw_req_t;

  // SRAM size code to AXI AxSIZE.
  function automatic logic [AXSIZE_W-1:0] to_axsize(input logic [SIZE_W-1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/axi_sram_bridge_rd_cnt.sv
// Outstanding-read counter for one AXI read id, saturating at 0 and MAX_OUT.
module axi_rd_cnt #(
  parameter  int unsigned MAX_OUT = 2,
  localparam int unsigned CW      = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt
);

  // Count grants up and R handshakes down; simultaneous events cancel.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != CW'(MAX_OUT))) begin
      cnt <= cnt + CW'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/axi_sram_bridge.sv
// Bridges the inst-fetch and data SRAM-like ports onto one AXI3 master, data port first.
module axi_sram_bridge
  import axi_sram_bridge_pkg::*;
#(
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                clk,
  input  logic                resetn,
  // instruction port
  input  logic                inst_sram_req,
  input  logic [SIZE_W-1:0]   inst_sram_size,
  input  logic [ADDR_W-1:0]   inst_sram_addr,
  output logic                inst_sram_addr_ok,
  output logic                inst_sram_data_ok,
  output logic [DATA_W-1:0]   inst_sram_rdata,
  // data port
  input  logic                data_sram_req,
  input  logic                data_sram_wr,
  input  logic [SIZE_W-1:0]   data_sram_size,
  input  logic [STRB_W-1:0]   data_sram_wstrb,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic                data_sram_addr_ok,
  output logic                data_sram_data_ok,
  output logic [DATA_W-1:0]   data_sram_rdata,
  // AR channel
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [3:0]          arlen,
  output logic [AXSIZE_W-1:0] arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  // R channel
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rvalid,
  output logic                rready,
  // AW channel
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [3:0]          awlen,
  output logic [AXSIZE_W-1:0] awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  // W channel
  output logic [ID_W-1:0]     wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [STRB_W-1:0]   wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // B channel
  input  logic                bvalid,
  output logic                bready
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  ar_state_e ar_state, ar_state_d;
  w_state_e  w_state,  w_state_d;

  ar_req_t ar_q, ar_d;
  logic    arvalid_q, arvalid_d;
  aw_req_t aw_q, aw_d;
  logic    awvalid_q, awvalid_d;
  logic    wvalid_q, wvalid_d;

  logic              inst_ok_q, inst_ok_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic              data_ok_q, data_ok_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic [CNT_W-1:0] inst_cnt, data_cnt;
  logic             inst_full, data_full, data_empty;
  logic             data_rd_elig, inst_rd_elig, store_elig;
  logic             data_rd_grant, inst_grant, store_acc;
  logic             r_hs, r_inst, r_data;

  assign inst_full  = (inst_cnt == CNT_W'(MAX_OUT));
  assign data_full  = (data_cnt == CNT_W'(MAX_OUT));
  assign data_empty = (data_cnt == '0);

  // Responses are only ever owed for granted requests, so R and B are always accepted.
  assign rready = 1'b1;
  assign bready = 1'b1;

  assign r_hs   = rvalid & rready;
  assign r_inst = r_hs & (rid == ID_INST);
  assign r_data = r_hs & (rid == ID_DATA);

  // Data loads wait for any store to finish; stores wait for data loads to drain.
  assign data_rd_elig = data_sram_req & ~data_sram_wr & ~data_full & (w_state == W_IDLE);
  assign inst_rd_elig = inst_sram_req & ~inst_full;
  assign store_elig   = data_sram_req & data_sram_wr & data_empty &
                        ~((ar_state == AR_SEND) & (ar_q.id == ID_DATA));

  axi_rd_cnt #(.MAX_OUT(MAX_OUT)) u_inst_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (inst_grant),
    .dec    (r_inst),
    .cnt    (inst_cnt)
  );

  axi_rd_cnt #(.MAX_OUT(MAX_OUT)) u_data_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (data_rd_grant),
    .dec    (r_data),
    .cnt    (data_cnt)
  );

  // AR FSM: one grant per idle cycle, data read over inst read, hold until arready.
  always_comb begin
    ar_state_d    = ar_state;
    ar_d          = ar_q;
    arvalid_d     = arvalid_q;
    data_rd_grant = 1'b0;
    inst_grant    = 1'b0;
    case (ar_state)
      AR_IDLE: begin
        if (data_rd_elig) begin
          data_rd_grant = 1'b1;
          ar_d.id       = ID_DATA;
          ar_d.addr     = data_sram_addr;
          ar_d.size     = to_axsize(data_sram_size);
          arvalid_d     = 1'b1;
          ar_state_d    = AR_SEND;
        end else if (inst_rd_elig) begin
          inst_grant    = 1'b1;
          ar_d.id       = ID_INST;
          ar_d.addr     = inst_sram_addr;
          ar_d.size     = to_axsize(inst_sram_size);
          arvalid_d     = 1'b1;
          ar_state_d    = AR_SEND;
        end
      end
      AR_SEND: begin
        if (arready) begin
          arvalid_d  = 1'b0;
          ar_state_d = AR_IDLE;
        end
      end
      default: begin
        arvalid_d  = 1'b0;
        ar_state_d = AR_IDLE;
      end
    endcase
  end

  // W FSM: issue AW and W together, retire each on its own handshake, then wait for B.
  always_comb begin
    w_state_d = w_state;
    aw_d      = aw_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    store_acc = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (store_elig) begin
          store_acc = 1'b1;
          aw_d.addr = data_sram_addr;
          aw_d.size = to_axsize(data_sram_size);
          aw_d.data = data_sram_wdata;
          aw_d.strb = data_sram_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          w_state_d = W_SEND;
        end
      end
      W_SEND: begin
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (!awvalid_d && !wvalid_d) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid) begin
          w_state_d = W_IDLE;
        end
      end
      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        w_state_d = W_IDLE;
      end
    endcase
  end

  // Response routing: R data goes to the port named by rid, B completes the store.
  always_comb begin
    inst_ok_d    = r_inst;
    inst_rdata_d = r_inst ? rdata : inst_rdata_q;
    data_ok_d    = r_data | ((w_state == W_RESP) & bvalid);
    data_rdata_d = r_data ? rdata : data_rdata_q;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ar_state     <= AR_IDLE;
      w_state      <= W_IDLE;
      ar_q         <= '0;
      arvalid_q    <= 1'b0;
      aw_q         <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      inst_ok_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_ok_q    <= 1'b0;
      data_rdata_q <= '0;
    end else begin
      ar_state     <= ar_state_d;
      w_state      <= w_state_d;
      ar_q         <= ar_d;
      arvalid_q    <= arvalid_d;
      aw_q         <= aw_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      inst_ok_q    <= inst_ok_d;
      inst_rdata_q <= inst_rdata_d;
      data_ok_q    <= data_ok_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign inst_sram_addr_ok = inst_grant;
  assign data_sram_addr_ok = data_rd_grant | store_acc;
  assign inst_sram_data_ok = inst_ok_q;
  assign inst_sram_rdata   = inst_rdata_q;
  assign data_sram_data_ok = data_ok_q;
  assign data_sram_rdata   = data_rdata_q;

  assign arid    = ar_q.id;
  assign araddr  = ar_q.addr;
  assign arsize  = ar_q.size;
  assign arvalid = arvalid_q;
  assign arlen   = AX_LEN;
  assign arburst = AX_BURST;
  assign arlock  = AX_LOCK;
  assign arcache = AX_CACHE;
  assign arprot  = AX_PROT;

  assign awid    = WR_ID;
  assign awaddr  = aw_q.addr;
  assign awsize  = aw_q.size;
  assign awvalid = awvalid_q;
  assign awlen   = AX_LEN;
  assign awburst = AX_BURST;
  assign awlock  = AX_LOCK;
  assign awcache = AX_CACHE;
  assign awprot  = AX_PROT;

  assign wid     = WR_ID;
  assign wdata   = aw_q.data;
  assign wstrb   = aw_q.strb;
  assign wlast   = W_LAST;
  assign wvalid  = wvalid_q;

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Directed bench for axi_sram_bridge: arbitration, outstanding limits, store/load ordering, reset.
module tb_axi_sram_bridge;
  import axi_sram_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, rid, awid, wid, arlen, awlen, arcache, awcache;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]  wstrb;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_sram_bridge #(.MAX_OUT(2)) u_dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    inst_sram_req = 1'b0; inst_sram_size = 2'd0; inst_sram_addr = '0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0;
    data_sram_wstrb = '0; data_sram_addr = '0; data_sram_wdata = '0;
    arready = 1'b0; rid = '0; rdata = '0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    cyc(); cyc(); cyc();

    // Reset state
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_inst_ok", 32'(inst_sram_data_ok), 32'd0);
    chk("rst_data_ok", 32'(data_sram_data_ok), 32'd0);
    chk("rst_inst_rdata", inst_sram_rdata, 32'd0);
    chk("rst_data_rdata", data_sram_rdata, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_arid", 32'(arid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd1);
    chk("rst_bready", 32'(bready), 32'd1);
    chk("rst_wlast", 32'(wlast), 32'd1);
    chk("rst_awid", 32'(awid), 32'd1);
    chk("rst_arburst", 32'(arburst), 32'd1);
    resetn = 1'b1;
    cyc();

    // Single inst fetch
    inst_sram_req = 1'b1; inst_sram_size = 2'd2; inst_sram_addr = 32'h1C00_0000; arready = 1'b1;
    settle();
    chk("t1_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    chk("t1_data_addr_ok", 32'(data_sram_addr_ok), 32'd0);
    cyc();
    inst_sram_req = 1'b0;
    settle();
    chk("t1_arvalid", 32'(arvalid), 32'd1);
    chk("t1_araddr", araddr, 32'h1C00_0000);
    chk("t1_arid", 32'(arid), 32'd0);
    chk("t1_arsize", 32'(arsize), 32'd2);
    chk("t1_addr_ok_send", 32'(inst_sram_addr_ok), 32'd0);
    cyc();
    chk("t1_arvalid_drop", 32'(arvalid), 32'd0);
    cyc(); cyc();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0280_0C0C;
    chk("t1_inst_ok_pre", 32'(inst_sram_data_ok), 32'd0);
    cyc();
    rvalid = 1'b0;
    chk("t1_inst_ok", 32'(inst_sram_data_ok), 32'd1);
    chk("t1_inst_rdata", inst_sram_rdata, 32'h0280_0C0C);
    chk("t1_data_ok", 32'(data_sram_data_ok), 32'd0);
    cyc();
    chk("t1_inst_ok_pulse", 32'(inst_sram_data_ok), 32'd0);
    chk("t1_inst_cnt", 32'(u_dut.u_inst_cnt.cnt), 32'd0);
    arready = 1'b0;

    // Inst and data load in the same cycle: data first
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0004;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_size = 2'd2; data_sram_addr = 32'h8000_1000;
    settle();
    chk("t2_data_addr_ok", 32'(data_sram_addr_ok), 32'd1);
    chk("t2_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    cyc();
    data_sram_req = 1'b0; arready = 1'b1;
    settle();
    chk("t2_arvalid", 32'(arvalid), 32'd1);
    chk("t2_arid_data", 32'(arid), 32'd1);
    chk("t2_araddr_data", araddr, 32'h8000_1000);
    chk("t2_inst_wait", 32'(inst_sram_addr_ok), 32'd0);
    cyc();
    chk("t2_arvalid_drop", 32'(arvalid), 32'd0);
    chk("t2_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    cyc();
    inst_sram_req = 1'b0;
    chk("t2_arid_inst", 32'(arid), 32'd0);
    chk("t2_araddr_inst", araddr, 32'h1C00_0004);
    cyc();
    arready = 1'b0;
    chk("t2_data_cnt", 32'(u_dut.u_data_cnt.cnt), 32'd1);
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h1111_1111;
    cyc();
    rid = 4'd0; rdata = 32'h2222_2222;
    chk("t2_data_ok", 32'(data_sram_data_ok), 32'd1);
    chk("t2_data_rdata", data_sram_rdata, 32'h1111_1111);
    chk("t2_inst_ok_none", 32'(inst_sram_data_ok), 32'd0);
    cyc();
    rvalid = 1'b0;
    chk("t2_inst_ok", 32'(inst_sram_data_ok), 32'd1);
    chk("t2_inst_rdata", inst_sram_rdata, 32'h2222_2222);
    chk("t2_data_ok_pulse", 32'(data_sram_data_ok), 32'd0);
    cyc();

    // Outstanding limit on inst reads
    arready = 1'b1; inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_0100;
    settle();
    chk("t3_first_ok", 32'(inst_sram_addr_ok), 32'd1);
    cyc();
    inst_sram_addr = 32'h0000_0104;
    cyc();
    chk("t3_second_ok", 32'(inst_sram_addr_ok), 32'd1);
    cyc();
    inst_sram_addr = 32'h0000_0108;
    cyc();
    chk("t3_third_held", 32'(inst_sram_addr_ok), 32'd0);
    chk("t3_inst_cnt_full", 32'(u_dut.u_inst_cnt.cnt), 32'd2);
    cyc();
    chk("t3_third_held2", 32'(inst_sram_addr_ok), 32'd0);
    rvalid = 1'b1; rid = 4'd2; rdata = 32'hDEAD_BEEF;
    cyc();
    chk("t3_bad_rid_inst", 32'(inst_sram_data_ok), 32'd0);
    chk("t3_bad_rid_data", 32'(data_sram_data_ok), 32'd0);
    chk("t3_bad_rid_cnt", 32'(u_dut.u_inst_cnt.cnt), 32'd2);
    rid = 4'd0; rdata = 32'h3333_0000;
    settle();
    chk("t3_held_before_r", 32'(inst_sram_addr_ok), 32'd0);
    cyc();
    rvalid = 1'b0;
    settle();
    chk("t3_r_ok", 32'(inst_sram_data_ok), 32'd1);
    chk("t3_third_ok", 32'(inst_sram_addr_ok), 32'd1);
    cyc();
    inst_sram_req = 1'b0;
    chk("t3_araddr", araddr, 32'h0000_0108);
    cyc();
    rvalid = 1'b1; rid = 4'd0;
    cyc(); cyc();
    rvalid = 1'b0; arready = 1'b0;
    cyc();
    chk("t3_cnt_drained", 32'(u_dut.u_inst_cnt.cnt), 32'd0);

    // Byte store, AW ready two cycles before W ready, load held meanwhile
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = 2'd0;
    data_sram_wstrb = 4'b1000; data_sram_addr = 32'h8000_0003; data_sram_wdata = 32'hAABB_CCDD;
    settle();
    chk("t4_store_ok", 32'(data_sram_addr_ok), 32'd1);
    cyc();
    chk("t4_awvalid", 32'(awvalid), 32'd1);
    chk("t4_wvalid", 32'(wvalid), 32'd1);
    chk("t4_awaddr", awaddr, 32'h8000_0003);
    chk("t4_awsize", 32'(awsize), 32'd0);
    chk("t4_wstrb", 32'(wstrb), 32'h8);
    chk("t4_wdata", wdata, 32'hAABB_CCDD);
    data_sram_wr = 1'b0; data_sram_size = 2'd2; data_sram_addr = 32'h8000_0200;
    awready = 1'b1;
    settle();
    chk("t4_load_held0", 32'(data_sram_addr_ok), 32'd0);
    cyc();
    awready = 1'b0;
    chk("t4_awvalid_drop", 32'(awvalid), 32'd0);
    chk("t4_wvalid_hold", 32'(wvalid), 32'd1);
    chk("t4_load_held1", 32'(data_sram_addr_ok), 32'd0);
    cyc();
    wready = 1'b1;
    chk("t4_wvalid_hold2", 32'(wvalid), 32'd1);
    cyc();
    wready = 1'b0;
    chk("t4_wvalid_drop", 32'(wvalid), 32'd0);
    chk("t4_w_resp", 32'(u_dut.w_state), 32'(W_RESP));
    chk("t4_load_held2", 32'(data_sram_addr_ok), 32'd0);
    cyc();
    bvalid = 1'b1;
    chk("t4_data_ok_pre", 32'(data_sram_data_ok), 32'd0);
    cyc();
    bvalid = 1'b0;
    settle();
    chk("t4_store_done", 32'(data_sram_data_ok), 32'd1);
    chk("t4_rdata_kept", data_sram_rdata, 32'h1111_1111);
    chk("t4_load_ok", 32'(data_sram_addr_ok), 32'd1);
    cyc();
    data_sram_req = 1'b0; arready = 1'b1;
    chk("t4_data_ok_pulse", 32'(data_sram_data_ok), 32'd0);
    chk("t4_arid", 32'(arid), 32'd1);
    chk("t4_araddr", araddr, 32'h8000_0200);
    cyc();
    arready = 1'b0;

    // Store arriving while a load is outstanding
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = 2'd2;
    data_sram_wstrb = 4'hF; data_sram_addr = 32'h8000_0300; data_sram_wdata = 32'h1234_5678;
    settle();
    chk("t5_store_held0", 32'(data_sram_addr_ok), 32'd0);
    cyc();
    chk("t5_no_aw", 32'(awvalid), 32'd0);
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h4444_4444;
    settle();
    chk("t5_store_held1", 32'(data_sram_addr_ok), 32'd0);
    cyc();
    rvalid = 1'b0;
    settle();
    chk("t5_load_ok", 32'(data_sram_data_ok), 32'd1);
    chk("t5_load_rdata", data_sram_rdata, 32'h4444_4444);
    chk("t5_store_ok", 32'(data_sram_addr_ok), 32'd1);
    cyc();
    data_sram_req = 1'b0; awready = 1'b1; wready = 1'b1;
    chk("t5_ok_gap", 32'(data_sram_data_ok), 32'd0);
    chk("t5_awvalid", 32'(awvalid), 32'd1);
    chk("t5_awaddr", awaddr, 32'h8000_0300);
    cyc();
    awready = 1'b0; wready = 1'b0;
    chk("t5_valids_clear", 32'({awvalid, wvalid}), 32'd0);
    chk("t5_w_resp", 32'(u_dut.w_state), 32'(W_RESP));
    bvalid = 1'b1;
    cyc();
    bvalid = 1'b0;
    chk("t5_store_done", 32'(data_sram_data_ok), 32'd1);
    chk("t5_rdata_kept", data_sram_rdata, 32'h4444_4444);
    cyc();
    chk("t5_ok_pulse", 32'(data_sram_data_ok), 32'd0);

    // Store and inst read granted together, then reset mid-flight
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h8000_0400;
    data_sram_wdata = 32'hCAFE_F00D;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0010;
    settle();
    chk("t6_store_ok", 32'(data_sram_addr_ok), 32'd1);
    chk("t6_inst_ok", 32'(inst_sram_addr_ok), 32'd1);
    cyc();
    data_sram_req = 1'b0; inst_sram_req = 1'b0; resetn = 1'b0;
    chk("t6_valids_up", 32'({arvalid, awvalid, wvalid}), 32'h7);
    chk("t6_ar_send", 32'(u_dut.ar_state), 32'(AR_SEND));
    chk("t6_w_send", 32'(u_dut.w_state), 32'(W_SEND));
    chk("t6_inst_cnt", 32'(u_dut.u_inst_cnt.cnt), 32'd1);
    cyc();
    chk("t6_valids_rst", 32'({arvalid, awvalid, wvalid}), 32'd0);
    chk("t6_ar_idle", 32'(u_dut.ar_state), 32'(AR_IDLE));
    chk("t6_w_idle", 32'(u_dut.w_state), 32'(W_IDLE));
    chk("t6_inst_cnt_rst", 32'(u_dut.u_inst_cnt.cnt), 32'd0);
    chk("t6_data_cnt_rst", 32'(u_dut.u_data_cnt.cnt), 32'd0);
    chk("t6_awaddr_rst", awaddr, 32'd0);
    chk("t6_wdata_rst", wdata, 32'd0);
    resetn = 1'b1;
    cyc();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0020;
    settle();
    chk("t6_post_rst_ok", 32'(inst_sram_addr_ok), 32'd1);
    cyc();
    inst_sram_req = 1'b0;
    chk("t6_post_rst_ar", araddr, 32'h1C00_0020);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
